// File: rtl/johnson_code_monitor.sv
// Receiver for an 8-bit Johnson (twisted-ring) counter bus: synchronise, decode,
// classify each step and keep revolution and error counts.
module johnson_code_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int ERR_W       = 8,
  parameter int REV_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [7:0]       code_in,
  output logic [3:0]       pos,
  output logic             pos_valid,
  output logic             locked,
  output logic             step_up,
  output logic             step_dn,
  output logic             err_illegal,
  output logic             err_skip,
  output logic [ERR_W-1:0] err_cnt,
  output logic [REV_W-1:0] rev_cnt
);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t     state, state_nxt;
  logic [7:0] sample;
  logic [7:0] sample_inv;
  logic [3:0] ones;
  logic [3:0] k;
  logic [3:0] delta;
  logic       legal;
  logic [3:0] pos_nxt;
  logic       up_nxt, dn_nxt, ill_nxt, skip_nxt;
  logic       err_inc, rev_inc, rev_dec;

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign sample = code_in;
    end else begin : g_sync
      logic [7:0] stage [SYNC_STAGES];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= 8'h00;
        end else begin
          stage[0] <= code_in;
          for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
        end
      end
      assign sample = stage[SYNC_STAGES-1];
    end
  endgenerate

  // Upper half of the ring is the bitwise complement of a lower-half code,
  // so both halves reduce to "ones contiguous from bit 0".
  assign sample_inv = ~sample;
  assign legal = sample[7] ? ((sample_inv & (sample_inv + 8'd1)) == 8'h00)
                           : ((sample & (sample + 8'd1)) == 8'h00);
  assign ones  = 4'($countones(sample));
  assign k     = sample[7] ? (4'd0 - ones) : ones;
  assign delta = k - pos;

  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    up_nxt    = 1'b0;
    dn_nxt    = 1'b0;
    ill_nxt   = 1'b0;
    skip_nxt  = 1'b0;
    err_inc   = 1'b0;
    rev_inc   = 1'b0;
    rev_dec   = 1'b0;
    if (en) begin
      case (state)
        UNLOCKED: begin
          if (legal) begin
            pos_nxt   = k;
            state_nxt = LOCKED;
          end else begin
            ill_nxt = 1'b1;
            err_inc = 1'b1;
          end
        end
        LOCKED: begin
          if (!legal) begin
            ill_nxt   = 1'b1;
            err_inc   = 1'b1;
            state_nxt = UNLOCKED;
          end else if (delta == 4'd1) begin
            up_nxt  = 1'b1;
            pos_nxt = k;
            rev_inc = (pos == 4'd15);
          end else if (delta == 4'd15) begin
            dn_nxt  = 1'b1;
            pos_nxt = k;
            rev_dec = (pos == 4'd0);
          end else if (delta != 4'd0) begin
            skip_nxt = 1'b1;
            err_inc  = 1'b1;
            pos_nxt  = k;
          end
        end
        default: state_nxt = UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= UNLOCKED;
      pos         <= 4'd0;
      step_up     <= 1'b0;
      step_dn     <= 1'b0;
      err_illegal <= 1'b0;
      err_skip    <= 1'b0;
      err_cnt     <= '0;
      rev_cnt     <= '0;
    end else begin
      state       <= state_nxt;
      pos         <= pos_nxt;
      step_up     <= up_nxt;
      step_dn     <= dn_nxt;
      err_illegal <= ill_nxt;
      err_skip    <= skip_nxt;
      // A same-cycle clear wins, so the colliding event is deliberately lost.
      if (clr) begin
        err_cnt <= '0;
        rev_cnt <= '0;
      end else begin
        if (err_inc && (err_cnt != {ERR_W{1'b1}})) err_cnt <= err_cnt + ERR_W'(1);
        if (rev_inc)      rev_cnt <= rev_cnt + REV_W'(1);
        else if (rev_dec) rev_cnt <= rev_cnt - REV_W'(1);
      end
    end
  end

  assign locked    = (state == LOCKED);
  assign pos_valid = (state == LOCKED);

endmodule

// File: tb/tb_johnson_code_monitor.sv
// Directed bench for johnson_code_monitor with SYNC_STAGES=2 (three clocks code_in -> outputs).
module tb_johnson_code_monitor;

  logic       clk = 1'b0;
  logic       rst, en, clr;
  logic [7:0] code_in;
  logic [3:0] pos;
  logic       pos_valid, locked, step_up, step_dn, err_illegal, err_skip;
  logic [7:0] err_cnt, rev_cnt;

  int checks = 0;
  int errors = 0;
  int up_count;

  johnson_code_monitor #(.SYNC_STAGES(2), .ERR_W(8), .REV_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .code_in(code_in),
    .pos(pos), .pos_valid(pos_valid), .locked(locked),
    .step_up(step_up), .step_dn(step_dn),
    .err_illegal(err_illegal), .err_skip(err_skip),
    .err_cnt(err_cnt), .rev_cnt(rev_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] johnson(input int k);
    logic [8:0] one;
    one = 9'd1;
    if (k < 8) return 8'((one << k) - 9'd1);
    else       return ~8'((one << (k - 8)) - 9'd1);
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Holds one code long enough for it to reach the evaluate stage exactly once.
  task automatic applyStimulus(input logic [7:0] code);
    @(negedge clk);
    code_in = code;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; clr = 1'b0; code_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_pos", pos, 0);
    checkOutput("rst_locked", locked, 0);
    checkOutput("rst_valid", pos_valid, 0);
    checkOutput("rst_err", err_cnt, 0);
    checkOutput("rst_rev", rev_cnt, 0);

    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("lock0_locked", locked, 1);
    checkOutput("lock0_valid", pos_valid, 1);
    checkOutput("lock0_pos", pos, 0);
    checkOutput("lock0_up", step_up, 0);

    @(negedge clk);
    code_in = 8'h01;
    @(posedge clk); #1;
    checkOutput("lat_e1_pos", pos, 0);
    @(posedge clk); #1;
    checkOutput("lat_e2_up", step_up, 0);
    @(posedge clk); #1;
    checkOutput("lat_e3_up", step_up, 1);
    checkOutput("lat_e3_pos", pos, 1);

    // Full forward revolution streamed one code per clock.
    up_count = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      code_in = johnson((i + 2) % 16);
      @(posedge clk); #1;
      if (step_up) up_count++;
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (step_up) up_count++;
    end
    checkOutput("fwd_ups", up_count, 16);
    checkOutput("fwd_pos", pos, 1);
    checkOutput("fwd_rev", rev_cnt, 1);
    checkOutput("fwd_err", err_cnt, 0);

    applyStimulus(8'h00);
    checkOutput("dn1_pulse", step_dn, 1);
    checkOutput("dn1_pos", pos, 0);
    checkOutput("dn1_rev", rev_cnt, 1);

    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
    checkOutput("clr_rev", rev_cnt, 0);

    applyStimulus(8'h80);
    checkOutput("wrapdn_pulse", step_dn, 1);
    checkOutput("wrapdn_pos", pos, 15);
    checkOutput("wrapdn_rev", rev_cnt, 8'hFF);
    applyStimulus(8'hC0);
    checkOutput("dn14_pulse", step_dn, 1);
    checkOutput("dn14_pos", pos, 14);
    checkOutput("dn14_rev", rev_cnt, 8'hFF);

    applyStimulus(8'h55);
    checkOutput("ill1_pulse", err_illegal, 1);
    checkOutput("ill1_locked", locked, 0);
    checkOutput("ill1_pos", pos, 14);
    checkOutput("ill1_err", err_cnt, 1);
    applyStimulus(8'h03);
    checkOutput("relock2_pos", pos, 2);
    checkOutput("relock2_err", err_cnt, 3);
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
    checkOutput("clr2_err", err_cnt, 0);

    applyStimulus(8'h1F);
    checkOutput("skip_pulse", err_skip, 1);
    checkOutput("skip_pos", pos, 5);
    checkOutput("skip_err", err_cnt, 1);
    checkOutput("skip_locked", locked, 1);
    checkOutput("skip_up", step_up, 0);

    applyStimulus(8'h55);
    checkOutput("ill2_pulse", err_illegal, 1);
    checkOutput("ill2_locked", locked, 0);
    checkOutput("ill2_pos", pos, 5);
    checkOutput("ill2_err", err_cnt, 2);
    applyStimulus(8'h07);
    checkOutput("relock3_locked", locked, 1);
    checkOutput("relock3_pos", pos, 3);
    checkOutput("relock3_err", err_cnt, 4);
    checkOutput("relock3_up", step_up, 0);
    checkOutput("relock3_dn", step_dn, 0);

    // An illegal code held while unlocked counts every clock.
    @(negedge clk); code_in = 8'h55;
    repeat (300) @(posedge clk);
    #1;
    checkOutput("sat_err", err_cnt, 8'hFF);
    checkOutput("sat_pulse", err_illegal, 1);
    @(posedge clk); #1;
    checkOutput("sat_hold", err_cnt, 8'hFF);

    applyStimulus(8'h80);
    checkOutput("lock15_pos", pos, 15);
    checkOutput("lock15_locked", locked, 1);

    @(negedge clk); code_in = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
    checkOutput("clrwin_up", step_up, 1);
    checkOutput("clrwin_pos", pos, 0);
    checkOutput("clrwin_rev", rev_cnt, 0);
    checkOutput("clrwin_err", err_cnt, 0);

    @(negedge clk); en = 1'b0; code_in = 8'h55;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("en0_locked", locked, 1);
    checkOutput("en0_pos", pos, 0);
    checkOutput("en0_err", err_cnt, 0);
    checkOutput("en0_ill", err_illegal, 0);
    @(negedge clk); en = 1'b1;
    @(posedge clk); #1;
    checkOutput("en1_ill", err_illegal, 1);
    checkOutput("en1_err", err_cnt, 1);
    checkOutput("en1_locked", locked, 0);

    applyStimulus(8'hFF);
    checkOutput("ff_pos", pos, 8);
    checkOutput("ff_locked", locked, 1);
    checkOutput("ff_err", err_cnt, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/johnson_code_monitor.md
Name: johnson_code_monitor

Overview:
- Receiving end of our 8-bit Johnson (twisted-ring) counter interface.
- Samples an external Johnson-coded bus and synchronises it.
- Decodes the bus to a 4-bit position, classifies each step as up/down/hold/skip, and flags illegal codes.
- Keeps a signed revolution count and a saturating error count, and lets tiles check a Johnson source.

Parameters:
- SYNC_STAGES, 2, flops in the code_in synchroniser; legal 0..3; 0 means direct sampling.
- ERR_W, 8, width of err_cnt.
- REV_W, 8, width of rev_cnt; wraps two's-complement.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  evaluation enable; synchroniser runs regardless.
- clr  in  1  synchronous clear of err_cnt and rev_cnt.
- code_in  in  8  Johnson-coded input bus.
- pos  out  4  last decoded legal position 0..15.
- pos_valid  out  1  high while locked.
- locked  out  1  FSM in LOCKED.
- step_up  out  1  one-cycle pulse, +1 step.
- step_dn  out  1  one-cycle pulse, -1 step.
- err_illegal  out  1  one-cycle pulse, non-Johnson code.
- err_skip  out  1  one-cycle pulse, legal code but |delta| > 1.
- err_cnt  out  ERR_W  saturating error count.
- rev_cnt  out  REV_W  signed revolution count.

Behaviour:

Code definition:
- State k advances by next = {code[6:0], ~code[7]}.
- k=0 is 00000000, k=1 is 00000001, k=8 is 11111111, k=9 is 11111110, k=15 is 10000000.

Legality and decode:
- Legal: code[7]=0 with ones contiguous from bit 0; or code[7]=1 with ones contiguous from bit 7.
- Decode: if code[7]=0, k = popcount. If code[7]=1, k = (16 - popcount) mod 16 (all-ones gives 8).
- All other 240 codes are illegal.

Pipeline:
- code_in passes through SYNC_STAGES flops, then one registered evaluate stage.
- Latency from code_in to pos/pulses is SYNC_STAGES+1 clocks.
- Evaluation acts only when en=1. When en=0, all pulses are 0 and FSM, pos and counters hold.

FSM:
- UNLOCKED (reset state):
  - Legal code: pos<=k, go LOCKED, no step pulse.
  - Illegal code: err_illegal=1, err_cnt++, stay.
- LOCKED, delta = (k - pos) mod 16:
  - delta 0: hold, no pulse.
  - delta 1: step_up, pos<=k; rev_cnt++ if pos was 15.
  - delta 15: step_dn, pos<=k; rev_cnt-- if pos was 0.
  - Other delta: err_skip, err_cnt++, pos<=k, stay LOCKED.
  - Illegal code: err_illegal, err_cnt++, go UNLOCKED, pos holds.

Counters and clear:
- err_cnt saturates at all-ones; it never wraps.
- rev_cnt wraps modulo 2^REV_W.
- clr zeroes err_cnt and rev_cnt and has priority over a same-cycle increment or decrement (that event is not counted).
- clr does not affect FSM, pos or pulses.

Reset:
- rst=1 zeroes the synchroniser and every output.
- After reset: pos=0, pos_valid=0, locked=0, all pulses=0, err_cnt=0, rev_cnt=0, FSM in UNLOCKED.
- Mid-operation rst aborts in-flight samples. The synchroniser holds 00000000 after reset, so the first evaluation with en=1 locks at k=0.
- At most one of step_up, step_dn, err_illegal, err_skip is high in any cycle.

Test Plan:
1. Reset, SYNC_STAGES=2, en=1, code_in=00000000 -> locked=1 and pos=0 three clocks after release; no pulses.
2. Drive the forward sequence 00000000, 00000001, …, 10000000, 00000000, one per clock -> 16 step_up pulses, pos counts 0..15 then 0, rev_cnt=1, err_cnt=0.
3. From pos=0, drive 10000000 -> step_dn, pos=15, rev_cnt=-1 (8'hFF); then 11000000 -> step_dn, pos=14, rev_cnt unchanged.
4. Locked at pos=2 (00000011), drive 00011111 (k=5) -> err_skip, pos=5, err_cnt+1, still locked.
5. Drive 01010101 -> err_illegal, locked=0, pos holds, err_cnt+1; then 00000111 -> locked=1, pos=3, no step pulse.
6. Force err_cnt to 8'hFF via illegal codes, one more illegal -> stays 8'hFF. Assert clr on the same cycle as a rev_cnt increment -> both counters 0. Toggle en=0 while changing code -> outputs hold.
